// File: rtl/frame_phase_decoder.sv
// Receive-side framing decoder: finds the periodic low marker on Din, locks onto it and
// reconstructs the transmitter phase. Optional error counter built when FRAME_DEC_ERRCNT_EN is defined.
module frame_phase_decoder #(
    parameter int PERIOD     = 8,
    parameter int LOCK_CNT   = 3,
    parameter int UNLOCK_CNT = 3
) (
    input  logic                        Clock,
    input  logic                        Reset_n,
    input  logic                        Din,
    output logic                        Locked,
    output logic [$clog2(PERIOD)-1:0]   Phase,
    output logic                        Marker,
    output logic [7:0]                  ErrCount,
    output logic [1:0]                  Dbg_state
);

    localparam int PW = $clog2(PERIOD);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int MW = $clog2(UNLOCK_CNT + 1);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t          state_q;
    logic [PW-1:0]   phase_q, phase_d;
    logic [GW-1:0]   good_q, good_d;
    logic [MW-1:0]   miss_q, miss_d;
    logic            locked_q;
    logic            marker_q;
    logic            exp_mark, good, extra, missing;

    // Sample classification is relative to where the marker should fall in the frame.
    always_comb begin
        exp_mark = (phase_q == PW'(PERIOD - 1));
        good     = !Din && exp_mark;
        extra    = !Din && !exp_mark;
        missing  = Din && exp_mark;
        phase_d  = exp_mark ? '0 : phase_q + 1'b1;
        good_d   = good_q + 1'b1;
        miss_d   = miss_q + 1'b1;
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= SEARCH;
            phase_q  <= '0;
            good_q   <= '0;
            miss_q   <= '0;
            locked_q <= 1'b0;
            marker_q <= 1'b0;
        end else begin
            marker_q <= 1'b0;
            case (state_q)
                SEARCH: begin
                    phase_q <= '0;
                    if (!Din) begin
                        good_q  <= '0;
                        state_q <= VERIFY;
                    end
                end
                VERIFY: begin
                    if (good) begin
                        phase_q <= phase_d;
                        good_q  <= good_d;
                        if (good_d == GW'(LOCK_CNT)) begin
                            state_q  <= LOCKED;
                            locked_q <= 1'b1;
                            miss_q   <= '0;
                        end
                    end else if (extra) begin
                        phase_q <= '0;
                        good_q  <= '0;
                    end else if (missing) begin
                        state_q <= SEARCH;
                        phase_q <= '0;
                    end else begin
                        phase_q <= phase_d;
                    end
                end
                LOCKED: begin
                    // Phase free-runs here; errors never resync it.
                    if (good) begin
                        marker_q <= 1'b1;
                        miss_q   <= '0;
                        phase_q  <= phase_d;
                    end else if (extra || missing) begin
                        if (miss_d == MW'(UNLOCK_CNT)) begin
                            state_q  <= SEARCH;
                            locked_q <= 1'b0;
                            phase_q  <= '0;
                            miss_q   <= '0;
                        end else begin
                            miss_q  <= miss_d;
                            phase_q <= phase_d;
                        end
                    end else begin
                        phase_q <= phase_d;
                    end
                end
                default: begin
                    state_q  <= SEARCH;
                    phase_q  <= '0;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef FRAME_DEC_ERRCNT_EN
    logic [7:0] err_q;

    // Survives loss of lock; only reset clears it.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            err_q <= 8'd0;
        end else if ((state_q == LOCKED) && (extra || missing) && (err_q != 8'hFF)) begin
            err_q <= err_q + 8'd1;
        end
    end

    assign ErrCount = err_q;
`else
    assign ErrCount = 8'd0;
`endif

    assign Locked    = locked_q;
    assign Phase     = phase_q;
    assign Marker    = marker_q;
    assign Dbg_state = state_q;

endmodule
